if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC unit.
- Takes the current PC, issues one instruction-memory read at a time, and buffers the returned words with their PCs in a small FIFO for decode.
- Pulses the PC-advance enable when a fetch is granted.
- On a taken branch, flushes the FIFO and discards any in-flight response.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- AW, 32, PC / instruction-memory address width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- PC  in  AW  current PC from PC unit
- pc_en  out  1  PC unit advances to PC+4 this cycle
- flush  in  1  taken branch / unconditional branch redirect; PC unit loads target this cycle
- imem_req  out  1  fetch request
- imem_addr  out  AW  fetch address, equals PC while imem_req=1
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid, ≥1 cycle after grant
- imem_rdata  in  32  instruction word
- inst_valid  out  1  FIFO head valid
- inst  out  32  head instruction
- inst_pc  out  AW  PC of head instruction
- inst_ready  in  1  decode consumes head

Behaviour:
- Reset (async, rst_n=0): state=IDLE, FIFO count=0, read/write pointers=0, latched request PC=0.
  - Outputs at reset: inst_valid=0, inst=0, inst_pc=0, imem_req=0, imem_addr=0, pc_en=0.
- FSM states: IDLE (nothing outstanding), WAIT (granted, awaiting data), DROP (awaiting data to discard).
- IDLE:
  - imem_req = (count<DEPTH) & !flush; imem_addr=PC (0 when imem_req=0).
  - On imem_req & imem_gnt: pc_en=1 combinationally that cycle; latch PC as req_pc; go to WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid & !flush: push {req_pc, imem_rdata}; go to IDLE. A new request can issue the next cycle.
  - On flush without rvalid: go to DROP.
  - On flush with rvalid: data discarded; go to IDLE.
- DROP:
  - imem_req=0.
  - On imem_rvalid: discard data; go to IDLE.
  - flush in DROP: stay in DROP.
- Ordering: at most one outstanding request, so responses are in order. No push occurs when count=DEPTH; this is guaranteed by the issue condition, because a request is only issued with at least one free slot reserved.
- FIFO output: inst_valid = (count≠0); inst and inst_pc come from the head entry. When empty, inst and inst_pc hold their last value; bench ignores them.
- Pop: inst_valid & inst_ready & !flush.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Count is (log2(DEPTH)+1) bits, range 0..DEPTH.
- flush: count←0 and rptr←wptr at the next edge. inst_valid=0 from the cycle after flush. Flush overrides push and pop in the same cycle.
- Latency: grant cycle N, rvalid cycle M>N, inst_valid visible at M+1 if FIFO was empty.
- Full: count=DEPTH -> imem_req=0, pc_en=0, so the PC holds. Requests resume in the cycle after a pop.
- Reset mid-operation: in-flight response after reset deassertion is undefined; the memory is reset by the same rst_n.

Optional Feature:
- Macro: IF_FETCH_STALL_CNT_EN.
- When defined:
  - Extra output port fetch_stall_cnt (out, 32): counts cycles with inst_ready=1 & inst_valid=0 & flush=0.
  - Reset to 0; saturates at 32'hFFFF_FFFF.
  - Not cleared by flush.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, PC=0x0000_0000, gnt=1, rvalid 1 cycle after grant, inst_ready=1 -> pc_en pulses every 2nd cycle; decode sees inst_pc 0x0,0x4,0x8 in order with matching rdata.
- inst_ready=0, DEPTH=4, memory always grants and returns next cycle -> exactly 4 grants; count=4; imem_req=0 and pc_en=0 thereafter. One pop -> imem_req=1 next cycle.
- Grant at PC=0x10, flush in WAIT before rvalid, rvalid two cycles later with 0xDEADBEEF -> word not pushed; inst_valid stays 0; next request issues with new PC=0x40.
- FIFO holds 3 entries, flush with inst_ready=1 same cycle -> no pop counted; inst_valid=0 next cycle; count=0.
- Push and pop same cycle with count=2 -> count stays 2; order preserved.
- With IF_FETCH_STALL_CNT_EN defined: inst_ready=1, FIFO empty for 5 cycles (memory latency 5) -> fetch_stall_cnt=5. Assert rst_n=0 mid-run -> counter and all outputs 0 immediately.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: one outstanding imem read, returned words buffered with their PCs in a DEPTH-entry FIFO.
// Optional stall counter (fetch_stall_cnt) is built when IF_FETCH_STALL_CNT_EN is defined.
module if_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] PC,
   output logic          pc_en,
   input  logic          flush,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_gnt,
   input  logic          imem_rvalid,
   input  logic [31:0]   imem_rdata,
   output logic          inst_valid,
   output logic [31:0]   inst,
   output logic [AW-1:0] inst_pc,
   input  logic          inst_ready
`ifdef IF_FETCH_STALL_CNT_EN
   ,
   output logic [31:0]   fetch_stall_cnt
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   req_pc_q, req_pc_d;
   logic [31:0]     word_q [DEPTH];
   logic [AW-1:0]   pcs_q  [DEPTH];
   logic            push, pop, full;

   assign full       = (count_q == CW'(DEPTH));
   assign inst_valid = (count_q != '0);
   assign inst       = word_q[rptr_q];
   assign inst_pc    = pcs_q[rptr_q];
   assign pop        = inst_valid & inst_ready & ~flush;
   assign imem_addr  = imem_req ? PC : '0;

   // Request is gated by rst_n so every output reads zero while reset is held.
   always_comb begin
      state_d  = state_q;
      req_pc_d = req_pc_q;
      imem_req = 1'b0;
      pc_en    = 1'b0;
      push     = 1'b0;
      case (state_q)
         IDLE: begin
            imem_req = rst_n & ~full & ~flush;
            if (imem_req & imem_gnt) begin
               pc_en    = 1'b1;
               req_pc_d = PC;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (flush) begin
               state_d = imem_rvalid ? IDLE : DROP;
            end else if (imem_rvalid) begin
               push    = 1'b1;
               state_d = IDLE;
            end
         end
         DROP: begin
            if (imem_rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      if (flush) begin
         count_d = '0;
         rptr_d  = wptr_q;
      end else begin
         if (push) wptr_d = wptr_q + 1'b1;
         if (pop)  rptr_d = rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         rptr_q   <= '0;
         wptr_q   <= '0;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rptr_q   <= rptr_d;
         wptr_q   <= wptr_d;
         req_pc_q <= req_pc_d;
      end
   end

   // Storage is cleared on reset so inst/inst_pc read zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= '0;
            pcs_q[i]  <= '0;
         end
      end else if (push) begin
         word_q[wptr_q] <= imem_rdata;
         pcs_q[wptr_q]  <= req_pc_q;
      end
   end

`ifdef IF_FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (inst_ready & ~inst_valid & ~flush & (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign fetch_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: queue-based reference model, memory responder and PC unit model.
module tb_if_fetch_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] PC;
   logic          pc_en;
   logic          flush;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [31:0]   imem_rdata;
   logic          inst_valid;
   logic [31:0]   inst;
   logic [AW-1:0] inst_pc;
   logic          inst_ready;
`ifdef IF_FETCH_STALL_CNT_EN
   logic [31:0]   fetch_stall_cnt;
`endif

   if_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .PC(PC), .pc_en(pc_en), .flush(flush),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
`ifdef IF_FETCH_STALL_CNT_EN
      , .fetch_stall_cnt(fetch_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // stimulus knobs (percent probabilities, latency range)
   int k_gnt, k_ready, k_flush, k_lat_min, k_lat_max;
   bit k_fix_en;
   logic [31:0] k_fix;

   // reference model
   logic [AW-1:0] pc_m, tgt, opc;
   logic [AW-1:0] fq_pc[$];
   logic [31:0]   fq_w[$];
   bit            outst, drop, mem_busy;
   int            mem_wait;
   longint        stall_m;
   bit            exp_req, exp_pc_en, exp_valid;
   logic [AW-1:0] exp_addr, exp_pc;
   logic [31:0]   exp_inst;

   task automatic model_reset();
      fq_pc.delete();
      fq_w.delete();
      outst = 0; drop = 0; mem_busy = 0; mem_wait = 0;
      pc_m = '0; stall_m = 0; opc = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      flush = 0; imem_gnt = 0; imem_rvalid = 0; inst_ready = 0; imem_rdata = '0; PC = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive();
      @(negedge clk);
      flush       = (int'($urandom_range(99)) < k_flush);
      imem_gnt    = (int'($urandom_range(99)) < k_gnt);
      inst_ready  = (int'($urandom_range(99)) < k_ready);
      tgt         = $urandom();
      tgt[1:0]    = 2'b00;
      imem_rvalid = mem_busy && (mem_wait == 0);
      imem_rdata  = (imem_rvalid && k_fix_en) ? k_fix : $urandom();
      PC          = pc_m;
      #2;
      exp_req   = !outst && (fq_pc.size() < DEPTH) && !flush;
      exp_addr  = exp_req ? pc_m : '0;
      exp_pc_en = exp_req && imem_gnt;
      exp_valid = (fq_pc.size() != 0);
      if (exp_valid) begin
         exp_pc   = fq_pc[0];
         exp_inst = fq_w[0];
      end
   endtask

   task automatic commit();
      if (inst_ready && !exp_valid && !flush) stall_m++;
      if (flush) begin
         fq_pc.delete();
         fq_w.delete();
         if (outst) begin
            if (imem_rvalid) begin outst = 0; drop = 0; end
            else drop = 1;
         end
      end else begin
         if (exp_valid && inst_ready) begin
            void'(fq_pc.pop_front());
            void'(fq_w.pop_front());
         end
         if (outst && imem_rvalid) begin
            if (!drop) begin
               fq_pc.push_back(opc);
               fq_w.push_back(imem_rdata);
            end
            outst = 0;
            drop = 0;
         end
      end
      if (exp_pc_en) begin outst = 1; drop = 0; opc = pc_m; end
      if (imem_rvalid) mem_busy = 0;
      else if (mem_busy) mem_wait--;
      if (exp_pc_en) begin
         mem_busy = 1;
         mem_wait = int'($urandom_range(k_lat_max, k_lat_min)) - 1;
      end
      pc_m = flush ? tgt : (exp_pc_en ? pc_m + 32'd4 : pc_m);
   endtask

   task automatic set_knobs(int g, int r, int f, int lmin, int lmax);
      k_gnt = g; k_ready = r; k_flush = f; k_lat_min = lmin; k_lat_max = lmax; k_fix_en = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      PC = 32'h1234; imem_gnt = 1; inst_ready = 1; flush = 0; imem_rvalid = 1; imem_rdata = 32'h5555_AAAA;
      #12;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
      checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
      checks++; if (inst_pc !== '0) begin failures++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req got=%b exp=0", imem_req); end
      checks++; if (imem_addr !== '0) begin failures++; $display("FAIL reset_imem_addr got=%h exp=0", imem_addr); end
      checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL reset_pc_en got=%b exp=0", pc_en); end
`ifdef IF_FETCH_STALL_CNT_EN
      checks++; if (fetch_stall_cnt !== 32'h0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", fetch_stall_cnt); end
`endif
      do_reset();
   endtask

   task automatic test_stream();
      int npop = 0;
      do_reset();
      set_knobs(100, 100, 0, 1, 1);
      for (int i = 0; i < 12; i++) begin
         drive();
         checks++;
         if (pc_en !== (i % 2 == 0)) begin failures++; $display("FAIL stream_pc_en cyc=%0d got=%b exp=%b", i, pc_en, (i % 2 == 0)); end
         if (inst_valid && inst_ready) begin
            checks++;
            if (inst_pc !== AW'(npop * 4)) begin failures++; $display("FAIL stream_inst_pc cyc=%0d got=%h exp=%h", i, inst_pc, AW'(npop * 4)); end
            checks++;
            if (!exp_valid || inst !== exp_inst) begin failures++; $display("FAIL stream_inst cyc=%0d got=%h exp=%h", i, inst, exp_inst); end
            npop++;
         end
         commit();
      end
      checks++; if (npop != 5) begin failures++; $display("FAIL stream_pop_count got=%0d exp=5", npop); end
   endtask

   task automatic test_full();
      int ng = 0;
      do_reset();
      set_knobs(100, 0, 0, 1, 1);
      for (int i = 0; i < 12; i++) begin
         drive();
         if (pc_en) ng++;
         commit();
      end
      checks++; if (ng != DEPTH) begin failures++; $display("FAIL full_grants got=%0d exp=%0d", ng, DEPTH); end
      drive();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL full_req got=%b exp=0", imem_req); end
      checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL full_pc_en got=%b exp=0", pc_en); end
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin failures++; $display("FAIL full_head got=%b/%h exp=1/0", inst_valid, inst_pc); end
      commit();
      k_ready = 100;
      drive();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL full_pop_cycle_req got=%b exp=0", imem_req); end
      commit();
      k_ready = 0;
      drive();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL full_resume got=%b/%h exp=1/00000010", imem_req, imem_addr); end
      checks++; if (inst_pc !== 32'h4) begin failures++; $display("FAIL full_after_pop_head got=%h exp=00000004", inst_pc); end
      commit();
   endtask

   task automatic test_flush_wait();
      do_reset();
      pc_m = 32'h10;
      set_knobs(100, 100, 0, 3, 3);
      k_fix_en = 1; k_fix = 32'hDEAD_BEEF;
      drive();
      checks++; if (pc_en !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL fw_grant got=%b/%h exp=1/00000010", pc_en, imem_addr); end
      commit();
      k_flush = 100;
      drive();
      tgt = 32'h40;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL fw_req_flush got=%b exp=0", imem_req); end
      commit();
      k_flush = 0;
      for (int i = 0; i < 2; i++) begin
         drive();
         checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL fw_drop cyc=%0d got=%b/%b exp=0/0", i, imem_req, inst_valid); end
         commit();
      end
      drive();
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL fw_not_pushed got=%b exp=0", inst_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL fw_new_req got=%b/%h exp=1/00000040", imem_req, imem_addr); end
      commit();
   endtask

   task automatic test_flush_entries();
      do_reset();
      set_knobs(100, 0, 0, 1, 1);
      for (int i = 0; i < 6; i++) begin drive(); commit(); end
      k_flush = 100; k_ready = 100;
      drive();
      tgt = 32'h200;
      checks++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL fe_pre got=%b/%b exp=1/0", inst_valid, imem_req); end
      commit();
      k_flush = 0; k_ready = 0;
      drive();
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL fe_valid_after got=%b exp=0", inst_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL fe_req got=%b/%h exp=1/00000200", imem_req, imem_addr); end
      commit();
      drive();
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL fe_empty got=%b exp=0", inst_valid); end
      commit();
      drive();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== exp_inst) begin
         failures++; $display("FAIL fe_head got=%b/%h/%h exp=1/00000200/%h", inst_valid, inst_pc, inst, exp_inst); end
      commit();
   endtask

   task automatic test_push_pop();
      do_reset();
      set_knobs(100, 0, 0, 1, 1);
      for (int i = 0; i < 5; i++) begin drive(); commit(); end
      k_ready = 100;
      drive();
      checks++; if (imem_rvalid !== 1'b1 || inst_pc !== 32'h0) begin failures++; $display("FAIL pp_head0 got=%h exp=00000000", inst_pc); end
      commit();
      k_gnt = 0;
      drive();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin failures++; $display("FAIL pp_head1 got=%b/%h exp=1/00000004", inst_valid, inst_pc); end
      commit();
      drive();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8) begin failures++; $display("FAIL pp_head2 got=%b/%h exp=1/00000008", inst_valid, inst_pc); end
      commit();
      drive();
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL pp_empty got=%b exp=0", inst_valid); end
      commit();
   endtask

`ifdef IF_FETCH_STALL_CNT_EN
   task automatic test_stall_cnt();
      do_reset();
      set_knobs(100, 100, 0, 5, 5);
      for (int i = 0; i < 8; i++) begin drive(); commit(); end
      k_flush = 100;
      drive(); commit();
      k_flush = 0;
      drive();
      checks++; if (fetch_stall_cnt !== 32'(stall_m)) begin failures++; $display("FAIL stall_cnt got=%0d exp=%0d", fetch_stall_cnt, stall_m); end
      commit();
   endtask
`endif

   task automatic test_random();
      do_reset();
      set_knobs(70, 60, 8, 1, 4);
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) begin
            k_gnt = int'($urandom_range(100, 30));
            k_ready = int'($urandom_range(100, 10));
         end
         drive();
         checks++; if (imem_req !== exp_req) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, imem_req, exp_req); end
         checks++; if (imem_addr !== exp_addr) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, imem_addr, exp_addr); end
         checks++; if (pc_en !== exp_pc_en) begin failures++; $display("FAIL rnd_pc_en cyc=%0d got=%b exp=%b", i, pc_en, exp_pc_en); end
         checks++; if (inst_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, inst_valid, exp_valid); end
         if (exp_valid) begin
            checks++; if (inst !== exp_inst || inst_pc !== exp_pc) begin
               failures++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", i, inst_pc, inst, exp_pc, exp_inst); end
         end
`ifdef IF_FETCH_STALL_CNT_EN
         checks++; if (fetch_stall_cnt !== 32'(stall_m)) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", i, fetch_stall_cnt, stall_m); end
`endif
         commit();
      end
   endtask

   task automatic test_reset_midrun();
      set_knobs(100, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin drive(); commit(); end
      drive();
      rst_n = 1'b0;
      #1;
      checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== '0) begin
         failures++; $display("FAIL midrst_fifo got=%b/%h/%h exp=0/0/0", inst_valid, inst, inst_pc); end
      checks++; if (imem_req !== 1'b0 || imem_addr !== '0 || pc_en !== 1'b0) begin
         failures++; $display("FAIL midrst_req got=%b/%h/%b exp=0/0/0", imem_req, imem_addr, pc_en); end
`ifdef IF_FETCH_STALL_CNT_EN
      checks++; if (fetch_stall_cnt !== 32'h0) begin failures++; $display("FAIL midrst_stall got=%0d exp=0", fetch_stall_cnt); end
`endif
      do_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_flush_wait();
      test_flush_entries();
      test_push_pop();
`ifdef IF_FETCH_STALL_CNT_EN
      test_stall_cnt();
`endif
      test_random();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
